// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRISC fetch stage: widths, reset vector and fetch FSM states.
package nrisc_pkg;

  localparam int LARGURA_PC    = 8;
  localparam int LARGURA_INSTR = 8;
  localparam logic [LARGURA_PC-1:0] VETOR_RESET = 8'h00;

  typedef enum logic [1:0] {
    OCIOSO,
    BUSCA,
    ENTREGA,
    PARADO
  } estado_t;

endpackage

// File: rtl/contador_pc.sv
// Program counter register: synchronous reset, then load, then increment, otherwise hold.
module contador_pc #(
  parameter int                 LARGURA     = 8,
  parameter logic [LARGURA-1:0] VALOR_RESET = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Carregar,
  input  logic               Incrementar,
  input  logic [LARGURA-1:0] Valor,
  output logic [LARGURA-1:0] Contagem
);

  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Contagem <= VALOR_RESET;
    end else if (Carregar) begin
      Contagem <= Valor;
    end else if (Incrementar) begin
      Contagem <= Contagem + LARGURA'(1);
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: requests one word per PC from instruction memory and hands it
// to the register-file stage, honouring halt, branch and downstream stall.
module busca_instrucao #(
  parameter int                    LARGURA_PC  = nrisc_pkg::LARGURA_PC,
  parameter logic [LARGURA_PC-1:0] VETOR_RESET = nrisc_pkg::VETOR_RESET
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               Halt,
  input  logic                               Desvio,
  input  logic [LARGURA_PC-1:0]              AlvoDesvio,
  input  logic                               Stall,
  input  logic                               MemPronto,
  input  logic [nrisc_pkg::LARGURA_INSTR-1:0] MemDado,
  output logic                               MemLer,
  output logic [LARGURA_PC-1:0]              MemEndereco,
  output logic [nrisc_pkg::LARGURA_INSTR-1:0] Instr,
  output logic                               InstrValida,
  output logic [LARGURA_PC-1:0]              PC,
  output logic                               Parado
);

  import nrisc_pkg::*;

  estado_t                  estado, proximo;
  logic                     haltPendente, haltAtivo;
  logic                     pcCarregar, pcIncrementar, instrCarregar;
  logic [LARGURA_INSTR-1:0] instrReg;

  // A halt seen during a fetch is remembered until the outstanding read completes.
  assign haltAtivo = Halt | haltPendente;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado       <= OCIOSO;
      haltPendente <= 1'b0;
    end else begin
      estado       <= proximo;
      haltPendente <= (estado == BUSCA && proximo == BUSCA) ? haltAtivo : 1'b0;
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    proximo = estado;
    unique case (estado)
      OCIOSO:  proximo = Halt ? PARADO : BUSCA;
      BUSCA: begin
        if (Desvio)         proximo = haltAtivo ? PARADO : BUSCA;
        else if (MemPronto) proximo = haltAtivo ? PARADO : ENTREGA;
      end
      ENTREGA: begin
        if (Halt)                 proximo = PARADO;
        else if (Desvio || !Stall) proximo = BUSCA;
      end
      PARADO:  proximo = PARADO;
    endcase
  end

  // A branch in BUSCA withdraws the request in the same cycle, so its data is never captured.
  always_comb begin
    MemLer        = (estado == BUSCA) && !Desvio;
    pcCarregar    = Desvio && (estado != PARADO);
    pcIncrementar = (estado == ENTREGA) && !Halt && !Stall;
    instrCarregar = (estado == BUSCA) && !Desvio && MemPronto && !haltAtivo;
    InstrValida   = (estado == ENTREGA);
    Parado        = (estado == PARADO);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      instrReg <= '0;
    end else if (instrCarregar) begin
      instrReg <= MemDado;
    end
  end

  contador_pc #(
    .LARGURA     (LARGURA_PC),
    .VALOR_RESET (VETOR_RESET)
  ) u_contador_pc (
    .Clock       (Clock),
    .Reset       (Reset),
    .Carregar    (pcCarregar),
    .Incrementar (pcIncrementar),
    .Valor       (AlvoDesvio),
    .Contagem    (PC)
  );

  assign MemEndereco = PC;
  assign Instr       = instrReg;

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: directed scenarios plus a randomized run
// scored against a transaction-level model of the fetch/deliver behaviour.
module tb_busca_instrucao;

  logic       Clock = 1'b0;
  logic       Reset, Halt, Desvio, Stall, MemPronto;
  logic [7:0] AlvoDesvio, MemDado;
  logic       MemLer, InstrValida, Parado;
  logic [7:0] MemEndereco, Instr, PC;

  int comparados  = 0;
  int divergentes = 0;

  busca_instrucao dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Halt        (Halt),
    .Desvio      (Desvio),
    .AlvoDesvio  (AlvoDesvio),
    .Stall       (Stall),
    .MemPronto   (MemPronto),
    .MemDado     (MemDado),
    .MemLer      (MemLer),
    .MemEndereco (MemEndereco),
    .Instr       (Instr),
    .InstrValida (InstrValida),
    .PC          (PC),
    .Parado      (Parado)
  );

  always #5 Clock = ~Clock;

  task automatic passo(input logic h, input logic d, input logic [7:0] alvo,
                       input logic s, input logic mp, input logic [7:0] md);
    Halt = h; Desvio = d; AlvoDesvio = alvo; Stall = s; MemPronto = mp; MemDado = md;
    @(posedge Clock); #1;
  endtask

  task automatic reinicia();
    Reset = 1'b1;
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    reinicia();
    comparados++; if (PC !== 8'h00) begin divergentes++; $display("FAIL reset_pc: got %h exp %h", PC, 8'h00); end
    comparados++; if (MemLer !== 1'b0) begin divergentes++; $display("FAIL reset_memler: got %b exp 0", MemLer); end
    comparados++; if (InstrValida !== 1'b0) begin divergentes++; $display("FAIL reset_valida: got %b exp 0", InstrValida); end
    comparados++; if (Parado !== 1'b0) begin divergentes++; $display("FAIL reset_parado: got %b exp 0", Parado); end
    comparados++; if (Instr !== 8'h00) begin divergentes++; $display("FAIL reset_instr: got %h exp 00", Instr); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (MemLer !== 1'b1) begin divergentes++; $display("FAIL ocioso_para_busca: MemLer got %b exp 1", MemLer); end
  endtask

  task automatic test_sequencia();
    reinicia();
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (MemLer !== 1'b1 || MemEndereco !== 8'h00) begin divergentes++; $display("FAIL seq_espera: MemLer %b addr %h exp 1/00", MemLer, MemEndereco); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12);
    comparados++; if (InstrValida !== 1'b1 || Instr !== 8'h12 || PC !== 8'h00) begin divergentes++; $display("FAIL seq_primeira: valida %b instr %h pc %h exp 1/12/00", InstrValida, Instr, PC); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (InstrValida !== 1'b0 || PC !== 8'h01 || MemEndereco !== 8'h01) begin divergentes++; $display("FAIL seq_pc01: valida %b pc %h addr %h exp 0/01/01", InstrValida, PC, MemEndereco); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h34);
    comparados++; if (InstrValida !== 1'b1 || Instr !== 8'h34) begin divergentes++; $display("FAIL seq_segunda: valida %b instr %h exp 1/34", InstrValida, Instr); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (PC !== 8'h02) begin divergentes++; $display("FAIL seq_pc02: got %h exp 02", PC); end
  endtask

  task automatic test_stall();
    reinicia();
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12);
    for (int i = 0; i < 3; i++) begin
      passo(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
      comparados++;
      if (InstrValida !== 1'b1 || Instr !== 8'h12 || PC !== 8'h00) begin
        divergentes++; $display("FAIL stall_hold[%0d]: valida %b instr %h pc %h exp 1/12/00", i, InstrValida, Instr, PC);
      end
    end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (InstrValida !== 1'b0 || PC !== 8'h01) begin divergentes++; $display("FAIL stall_release: valida %b pc %h exp 0/01", InstrValida, PC); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (PC !== 8'h01) begin divergentes++; $display("FAIL stall_once: pc %h exp 01", PC); end
  endtask

  task automatic test_desvio_busca();
    reinicia();
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    Desvio = 1'b1; AlvoDesvio = 8'h40; MemPronto = 1'b1; MemDado = 8'hAA;
    #1;
    comparados++; if (MemLer !== 1'b0) begin divergentes++; $display("FAIL desvio_withdraw: MemLer %b exp 0", MemLer); end
    @(posedge Clock); #1;
    comparados++; if (InstrValida !== 1'b0 || MemEndereco !== 8'h40) begin divergentes++; $display("FAIL desvio_alvo: valida %b addr %h exp 0/40", InstrValida, MemEndereco); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
    comparados++; if (InstrValida !== 1'b1 || Instr !== 8'h55 || PC !== 8'h40) begin divergentes++; $display("FAIL desvio_busca_nova: valida %b instr %h pc %h exp 1/55/40", InstrValida, Instr, PC); end
  endtask

  task automatic test_wrap();
    reinicia();
    passo(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77);
    comparados++; if (InstrValida !== 1'b1 || PC !== 8'hFF) begin divergentes++; $display("FAIL wrap_ff: valida %b pc %h exp 1/ff", InstrValida, PC); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (MemEndereco !== 8'h00 || MemLer !== 1'b1) begin divergentes++; $display("FAIL wrap_00: addr %h MemLer %b exp 00/1", MemEndereco, MemLer); end
  endtask

  task automatic test_halt_busca();
    reinicia();
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    passo(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (MemLer !== 1'b1 || Parado !== 1'b0) begin divergentes++; $display("FAIL halt_hold1: MemLer %b parado %b exp 1/0", MemLer, Parado); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    comparados++; if (MemLer !== 1'b1) begin divergentes++; $display("FAIL halt_hold2: MemLer %b exp 1", MemLer); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h99);
    comparados++; if (Parado !== 1'b1 || InstrValida !== 1'b0 || MemLer !== 1'b0 || Instr !== 8'h00) begin divergentes++; $display("FAIL halt_parado: parado %b valida %b MemLer %b instr %h exp 1/0/0/00", Parado, InstrValida, MemLer, Instr); end
    passo(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h11);
    comparados++; if (PC !== 8'h00 || Parado !== 1'b1) begin divergentes++; $display("FAIL halt_desvio_ignorado: pc %h parado %b exp 00/1", PC, Parado); end
    reinicia();
    comparados++; if (Parado !== 1'b0) begin divergentes++; $display("FAIL halt_reset_sai: parado %b exp 0", Parado); end
    passo(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    comparados++; if (Parado !== 1'b1 || PC !== 8'h33 || MemLer !== 1'b0) begin divergentes++; $display("FAIL halt_e_desvio: parado %b pc %h MemLer %b exp 1/33/0", Parado, PC, MemLer); end
  endtask

  task automatic test_reset_meio_busca();
    reinicia();
    passo(1'b0, 1'b1, 8'h21, 1'b0, 1'b0, 8'h00);
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    Reset = 1'b1;
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hBB);
    Reset = 1'b0;
    comparados++; if (MemLer !== 1'b0 || PC !== 8'h00 || InstrValida !== 1'b0 || Instr !== 8'h00) begin divergentes++; $display("FAIL reset_busca: MemLer %b pc %h valida %b instr %h exp 0/00/0/00", MemLer, PC, InstrValida, Instr); end
    passo(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hCC);
    comparados++; if (InstrValida !== 1'b0 || MemLer !== 1'b1) begin divergentes++; $display("FAIL reset_resposta_tardia: valida %b MemLer %b exp 0/1", InstrValida, MemLer); end
  endtask

  task automatic test_aleatorio();
    logic [7:0] mem [256];
    logic [7:0] ePC, eInstr, alvo;
    logic       eValida, eBusca, eLer, d, s, mp;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'hEE) mem[i] = 8'h00;
    end
    reinicia();
    ePC = 8'h00; eInstr = 8'h00; eValida = 1'b0; eBusca = 1'b0;
    for (int c = 0; c < 600; c++) begin
      d    = ($urandom_range(0, 9) == 0);
      s    = ($urandom_range(0, 2) == 0);
      mp   = ($urandom_range(0, 1) == 1);
      alvo = 8'($urandom);
      Halt = 1'b0; Desvio = d; Stall = s; AlvoDesvio = alvo; MemPronto = 1'b0;
      #1;
      eLer = eBusca && !eValida && !d;
      comparados++; if (MemLer !== eLer || MemEndereco !== ePC) begin divergentes++; $display("FAIL rnd_pedido[%0d]: MemLer %b addr %h exp %b/%h", c, MemLer, MemEndereco, eLer, ePC); end
      MemPronto = mp;
      MemDado   = MemLer ? mem[MemEndereco] : 8'hEE;
      @(posedge Clock);
      if (d) begin
        ePC = alvo; eValida = 1'b0; eBusca = 1'b1;
      end else if (eValida) begin
        if (!s) begin ePC = ePC + 8'd1; eValida = 1'b0; end
      end else if (eLer && mp) begin
        eValida = 1'b1; eInstr = mem[ePC];
      end else begin
        eBusca = 1'b1;
      end
      #1;
      comparados++; if (PC !== ePC || InstrValida !== eValida) begin divergentes++; $display("FAIL rnd_estado[%0d]: pc %h valida %b exp %h/%b", c, PC, InstrValida, ePC, eValida); end
      if (eValida) begin
        comparados++; if (Instr !== eInstr) begin divergentes++; $display("FAIL rnd_instr[%0d]: got %h exp %h", c, Instr, eInstr); end
      end
    end
  endtask

  initial begin
    Reset = 1'b0; Halt = 1'b0; Desvio = 1'b0; Stall = 1'b0;
    MemPronto = 1'b0; MemDado = 8'h00; AlvoDesvio = 8'h00;
    test_reset();
    test_sequencia();
    test_stall();
    test_desvio_busca();
    test_wrap();
    test_halt_busca();
    test_reset_meio_busca();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 Parameter LARGURA_PC, default 8: width of the program counter and instruction-memory address.
REQ-002 Parameter VETOR_RESET, default 8'h00: PC value loaded on reset.
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Halt  input  1  processor stop request.
REQ-006 Desvio  input  1  branch/jump taken; load AlvoDesvio into PC.
REQ-007 AlvoDesvio  input  LARGURA_PC  branch target address.
REQ-008 Stall  input  1  downstream register-file stage not ready to accept Instr.
REQ-009 MemPronto  input  1  instruction memory has data on MemDado this cycle.
REQ-010 MemDado  input  8  instruction word from memory.
REQ-011 MemLer  output  1  read request to instruction memory.
REQ-012 MemEndereco  output  LARGURA_PC  read address, always equal to PC.
REQ-013 Instr  output  8  fetched instruction feeding the register-file stage.
REQ-014 InstrValida  output  1  Instr holds a valid instruction.
REQ-015 PC  output  LARGURA_PC  current program counter.
REQ-016 Parado  output  1  unit is halted.

Function
REQ-017 The FSM SHALL have four states: OCIOSO, BUSCA, ENTREGA, PARADO.
REQ-018 OCIOSO SHALL move to BUSCA on the next cycle unless Halt is high.
REQ-019 In BUSCA, MemLer SHALL be 1 and MemEndereco SHALL equal PC, held stable until MemPronto.
REQ-020 When MemPronto is sampled high in BUSCA at cycle n, Instr SHALL equal MemDado and InstrValida SHALL be 1 from cycle n+1, with the state moving to ENTREGA.
REQ-021 In ENTREGA with Stall=1, Instr, InstrValida and PC SHALL hold.
REQ-022 In ENTREGA with Stall=0, PC SHALL increment by 1 and the state SHALL return to BUSCA; InstrValida SHALL be 0 in the following cycle.
REQ-023 PC increment SHALL wrap modulo 2^LARGURA_PC: 8'hFF+1 -> 8'h00.
REQ-024 Desvio=1 in OCIOSO or ENTREGA SHALL load PC<=AlvoDesvio, clear InstrValida next cycle and enter BUSCA.
REQ-025 Desvio=1 in BUSCA SHALL withdraw the request, discard any same-cycle MemDado, load PC<=AlvoDesvio and restart BUSCA next cycle; memory SHALL tolerate a withdrawn MemLer.
REQ-026 Halt=1 in OCIOSO or ENTREGA SHALL enter PARADO next cycle with InstrValida=0.
REQ-027 Halt=1 in BUSCA SHALL keep MemLer until MemPronto, discard that data, then enter PARADO.
REQ-028 PARADO SHALL hold MemLer=0, InstrValida=0, Parado=1 and PC frozen; only Reset exits it.
REQ-029 Priority SHALL be Reset > Halt > Desvio > Stall; simultaneous Halt and Desvio SHALL load AlvoDesvio into PC and then halt.
REQ-030 Stall SHALL have no effect outside ENTREGA.

Reset
REQ-031 Reset sampled high SHALL, on that edge, set state=OCIOSO, PC=VETOR_RESET, Instr=8'h00, InstrValida=0, MemLer=0 and Parado=0, from any state, including mid-fetch.
REQ-032 A memory response arriving during or after a reset cycle for a request withdrawn by reset SHALL be ignored.

Structure
REQ-033 The shared package nrisc_pkg SHALL hold the FSM state enumeration, LARGURA_PC, the instruction width (8) and VETOR_RESET.
REQ-034 PC storage SHALL be a sub-module contador_pc with load, increment, hold and synchronous reset.
REQ-035 The block SHALL contain no combinational path from MemDado to Instr.

Verification
REQ-036 Reset, then memory returning 8'h12, 8'h34 with MemPronto one cycle after MemLer -> Instr 8'h12 then 8'h34, PC 00->01->02.
REQ-037 Stall held high for 3 cycles while in ENTREGA with Instr=8'h12 -> Instr, InstrValida and PC unchanged; on release PC increments exactly once.
REQ-038 Desvio with AlvoDesvio=8'h40 in BUSCA, in the same cycle as MemPronto with MemDado=8'hAA -> 8'hAA never valid; next MemEndereco=8'h40.
REQ-039 PC=8'hFF fetch completes with Stall=0 -> next MemEndereco=8'h00.
REQ-040 Halt raised in BUSCA with MemPronto delayed 2 cycles -> MemLer held, data discarded, Parado=1; Desvio afterwards leaves PC unchanged.
REQ-041 Reset asserted mid-BUSCA -> next cycle MemLer=0, PC=8'h00, InstrValida=0, state OCIOSO.
